// File: rtl/seg7_scan_driver_pkg.sv
// Shared 7-segment definitions: active-low {g,f,e,d,c,b,a} glyph patterns and the hex decoder function.
package seg7_scan_driver_pkg;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode hex display driver with frame-aligned word updates.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned CLKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_CYCLES   = 16
) (
    input  logic                  clk,
    input  logic                  RESET_N,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     en_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_pulse
);

    localparam int unsigned CW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                slot_end, boundary;

    logic [4*DIGITS-1:0] pend_val, sh_val, nxt_val;
    logic [DIGITS-1:0]   pend_dp, sh_dp, nxt_dp;
    logic [DIGITS-1:0]   pend_en, sh_en, nxt_en;
    logic                pend_valid;

    logic [DIGITS-1:0]   lz_dark;
    logic [DIGITS-1:0]   an_next;
    logic [3:0]          cur_nib;
    logic [6:0]          cur_seg;

    assign slot_end = (cnt == CNT_LAST);
    assign boundary = slot_end && (idx == IDX_LAST);

    // A load on the boundary edge wins over any pending word so the new frame shows it.
    always_comb begin
        nxt_val = sh_val;
        nxt_dp  = sh_dp;
        nxt_en  = sh_en;
        if (boundary) begin
            if (load) begin
                nxt_val = value_in;
                nxt_dp  = dp_in;
                nxt_en  = en_in;
            end else if (pend_valid) begin
                nxt_val = pend_val;
                nxt_dp  = pend_dp;
                nxt_en  = pend_en;
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic [DIGITS-1:0] lz_next;
    logic              all_zero;

    // Mask is taken from the word committed at the boundary, so it tracks the shadow exactly.
    always_comb begin
        lz_next  = '0;
        all_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS - 1; i++) begin
            all_zero = all_zero && (nxt_val[4*(DIGITS-1-i) +: 4] == 4'h0);
            lz_next[DIGITS-1-i] = all_zero && !nxt_dp[DIGITS-1-i];
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N)
            lz_dark <= '0;
        else if (boundary)
            lz_dark <= lz_next;
    end
`else
    assign lz_dark = '0;
`endif

    assign cur_nib = sh_val[idx*4 +: 4];

    seg7_hex_decode u_decode (
        .nibble (cur_nib),
        .seg    (cur_seg)
    );

    always_comb begin
        an_next = '1;
        if (cnt >= CNT_BLANK && sh_en[idx] && !lz_dark[idx])
            an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt         <= '0;
            idx         <= '0;
            pend_val    <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            pend_valid  <= 1'b0;
            sh_val      <= '0;
            sh_dp       <= '0;
            sh_en       <= '0;
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_pulse <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

            sh_val <= nxt_val;
            sh_dp  <= nxt_dp;
            sh_en  <= nxt_en;

            if (boundary) begin
                pend_valid <= 1'b0;
            end else if (load) begin
                pend_val   <= value_in;
                pend_dp    <= dp_in;
                pend_en    <= en_in;
                pend_valid <= 1'b1;
            end

            an          <= an_next;
            seg         <= cur_seg;
            dp          <= ~sh_dp[idx];
            frame_pulse <= boundary;
        end
    end

endmodule
